// File: rtl/ysyx_store_drain_if.sv
// Commit-channel, L1D write-channel and load-check signals of the store drain buffer.
// The slave modport is the buffer's view; master is the surrounding pipeline/bus.
interface ysyx_store_drain_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_store;
  logic [4:0]      in_alu;
  logic [XLEN-1:0] in_sq_waddr;
  logic [XLEN-1:0] in_sq_wdata;
  logic [XLEN-1:0] in_pc;
  logic            in_ready;

  logic            awvalid;
  logic [XLEN-1:0] awaddr;
  logic            wvalid;
  logic [XLEN-1:0] wdata;
  logic [7:0]      wstrb;
  logic            wready;

  logic [XLEN-1:0] lq_raddr;
  logic            lq_conflict;

  logic            sq_empty;
  logic [XLEN-1:0] head_pc;

  modport master (
    output in_valid, in_store, in_alu, in_sq_waddr, in_sq_wdata, in_pc,
    output wready, lq_raddr,
    input  in_ready, awvalid, awaddr, wvalid, wdata, wstrb,
    input  lq_conflict, sq_empty, head_pc
  );

  modport slave (
    input  in_valid, in_store, in_alu, in_sq_waddr, in_sq_wdata, in_pc,
    input  wready, lq_raddr,
    output in_ready, awvalid, awaddr, wvalid, wdata, wstrb,
    output lq_conflict, sq_empty, head_pc
  );
endinterface

// File: rtl/ysyx_store_drain.sv
// Committed-store buffer: queues retired stores and drains them one at a time
// onto the L1D write channel; also flags loads that overlap a pending store.
//
// state  | meaning
// S_IDLE | no write presented; leaves for S_SEND when the queue is non-empty
// S_SEND | head entry presented on aw/w; popped when wready is seen
module ysyx_store_drain #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  ysyx_store_drain_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t          r_state;
  logic [PW:0]     r_wptr;
  logic [PW:0]     r_rptr;
  logic [DEPTH-1:0] r_vld;

  // Byte address bits [1:0] are folded into the strobe/data at push time.
  logic [XLEN-1:2] r_addr [DEPTH];
  logic [XLEN-1:0] r_data [DEPTH];
  logic [3:0]      r_strb [DEPTH];
  logic [XLEN-1:0] r_pc   [DEPTH];

  logic [PW-1:0]   w_widx;
  logic [PW-1:0]   w_hidx;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_send;
  logic [1:0]      w_off;
  logic [3:0]      w_strb;
  logic [XLEN-1:0] w_sdata;
  logic            w_conflict;
  logic            w_unused;

  assign w_widx  = r_wptr[PW-1:0];
  assign w_hidx  = r_rptr[PW-1:0];
  assign w_full  = (r_wptr[PW-1:0] == r_rptr[PW-1:0]) && (r_wptr[PW] != r_rptr[PW]);
  assign w_empty = (r_wptr == r_rptr);
  assign w_send  = (r_state == S_SEND);
  assign w_push  = bus.in_valid && bus.in_store && !w_full;
  assign w_pop   = w_send && bus.wready;

  // Upper width-code bits carry no meaning here; load compare is word-granular.
  assign w_unused = ^{bus.in_alu[4:2], bus.lq_raddr[1:0]};

  // Lane placement of the incoming store: strobe and shifted data.
  // A halfword at offset 3 loses its upper byte; upstream traps on that case.
  always_comb begin
    w_off   = bus.in_sq_waddr[1:0];
    w_strb  = 4'b1111;
    case (bus.in_alu[1:0])
      2'b00:   w_strb = 4'b0001 << w_off;
      2'b01:   w_strb = 4'b0011 << w_off;
      default: w_strb = 4'b1111;
    endcase
    w_sdata = bus.in_sq_wdata << {w_off, 3'b000};
  end

  // Entry payload storage; only the valid bitmap needs a reset.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_addr[w_widx] <= bus.in_sq_waddr[XLEN-1:2];
      r_data[w_widx] <= w_sdata;
      r_strb[w_widx] <= w_strb;
      r_pc[w_widx]   <= bus.in_pc;
    end
  end

  // Pointers, valid bitmap and drain FSM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_vld   <= '0;
      r_state <= S_IDLE;
    end else begin
      if (w_push) begin
        r_wptr         <= r_wptr + PTR_ONE;
        r_vld[w_widx]  <= 1'b1;
      end
      if (w_pop) begin
        r_rptr         <= r_rptr + PTR_ONE;
        r_vld[w_hidx]  <= 1'b0;
      end
      case (r_state)
        S_IDLE:  if (!w_empty) r_state <= S_SEND;
        S_SEND:  if (bus.wready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Word-granular overlap check against every queued store.
  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_addr[i] == bus.lq_raddr[XLEN-1:2])) w_conflict = 1'b1;
    end
  end

  // Bus outputs depend on registered state only, so wready never reaches awvalid.
  assign bus.in_ready    = !w_full;
  assign bus.awvalid     = w_send;
  assign bus.wvalid      = w_send;
  assign bus.awaddr      = w_send ? {r_addr[w_hidx], 2'b00} : '0;
  assign bus.wdata       = w_send ? r_data[w_hidx] : '0;
  assign bus.wstrb       = w_send ? {4'b0000, r_strb[w_hidx]} : 8'h00;
  assign bus.lq_conflict = w_conflict;
  assign bus.sq_empty    = w_empty && (r_state == S_IDLE);
  assign bus.head_pc     = w_empty ? '0 : r_pc[w_hidx];
endmodule

// File: tb/tb_ysyx_store_drain.sv
// Directed bench for the committed-store drain buffer.
module tb_ysyx_store_drain;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  ysyx_store_drain_if #(.XLEN(32)) bus ();

  ysyx_store_drain #(.XLEN(32), .DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_store(input logic [31:0] addr, input logic [31:0] data,
                           input logic [4:0] alu, input logic [31:0] pc);
    bus.in_valid    = 1'b1;
    bus.in_store    = 1'b1;
    bus.in_sq_waddr = addr;
    bus.in_sq_wdata = data;
    bus.in_alu      = alu;
    bus.in_pc       = pc;
  endtask

  // Entry currently presented (wready must be 1): check, pop, then check the idle gap.
  task automatic drain_one(input string tag, input logic [31:0] addr, input logic [31:0] data);
    chk({tag, "_awvalid"}, {31'd0, bus.awvalid}, 32'd1);
    chk({tag, "_awaddr"}, bus.awaddr, addr);
    chk({tag, "_wdata"}, bus.wdata, data);
    step();
    chk({tag, "_gap"}, {31'd0, bus.awvalid}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_store = 1'b0;
    bus.in_alu = 5'd0;
    bus.in_sq_waddr = '0;
    bus.in_sq_wdata = '0;
    bus.in_pc = '0;
    bus.wready = 1'b0;
    bus.lq_raddr = '0;

    // Reset values
    #12;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_awvalid", {31'd0, bus.awvalid}, 32'd0);
    chk("rst_wvalid", {31'd0, bus.wvalid}, 32'd0);
    chk("rst_awaddr", bus.awaddr, 32'd0);
    chk("rst_wdata", bus.wdata, 32'd0);
    chk("rst_wstrb", {24'd0, bus.wstrb}, 32'd0);
    chk("rst_sq_empty", {31'd0, bus.sq_empty}, 32'd1);
    chk("rst_head_pc", bus.head_pc, 32'd0);
    chk("rst_lq_conflict", {31'd0, bus.lq_conflict}, 32'd0);
    reset = 1'b1;
    step();

    // Single word store, wready held high
    bus.wready = 1'b1;
    set_store(32'h8000_0004, 32'hDEAD_BEEF, 5'd2, 32'h0000_0100);
    step();
    bus.in_valid = 1'b0;
    chk("w_empty_after_push", {31'd0, bus.sq_empty}, 32'd0);
    chk("w_awvalid_push_edge", {31'd0, bus.awvalid}, 32'd0);
    chk("w_head_pc", bus.head_pc, 32'h0000_0100);
    step();
    chk("w_awvalid", {31'd0, bus.awvalid}, 32'd1);
    chk("w_wvalid", {31'd0, bus.wvalid}, 32'd1);
    chk("w_awaddr", bus.awaddr, 32'h8000_0004);
    chk("w_wdata", bus.wdata, 32'hDEAD_BEEF);
    chk("w_wstrb", {24'd0, bus.wstrb}, 32'h0000_000F);
    step();
    chk("w_awvalid_one_cycle", {31'd0, bus.awvalid}, 32'd0);
    chk("w_sq_empty_back", {31'd0, bus.sq_empty}, 32'd1);

    // Byte lane
    bus.wready = 1'b0;
    set_store(32'h8000_0003, 32'h0000_00AB, 5'd0, 32'h0000_0104);
    step();
    bus.in_valid = 1'b0;
    step();
    chk("b_wdata", bus.wdata, 32'hAB00_0000);
    chk("b_wstrb", {24'd0, bus.wstrb}, 32'h0000_0008);
    chk("b_awaddr", bus.awaddr, 32'h8000_0000);
    bus.wready = 1'b1;
    step();
    chk("b_sq_empty", {31'd0, bus.sq_empty}, 32'd1);

    // Halfword lane
    bus.wready = 1'b0;
    set_store(32'h8000_0002, 32'h0000_1234, 5'd1, 32'h0000_0108);
    step();
    bus.in_valid = 1'b0;
    step();
    chk("h_wdata", bus.wdata, 32'h1234_0000);
    chk("h_wstrb", {24'd0, bus.wstrb}, 32'h0000_000C);
    bus.wready = 1'b1;
    step();
    chk("h_sq_empty", {31'd0, bus.sq_empty}, 32'd1);

    // Back-pressure: fill all four entries
    bus.wready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      set_store(32'h8000_0100 + 32'(4 * k), 32'h1111_1111 * 32'(k), 5'd2, 32'h0000_0200 + 32'(k));
      step();
    end
    chk("f_in_ready_full", {31'd0, bus.in_ready}, 32'd0);
    chk("f_awvalid", {31'd0, bus.awvalid}, 32'd1);
    chk("f_awaddr", bus.awaddr, 32'h8000_0104);
    // Fifth push attempt while full
    set_store(32'h8000_0200, 32'h5555_5555, 5'd2, 32'h0000_02FF);
    step();
    chk("f_in_ready_still", {31'd0, bus.in_ready}, 32'd0);
    chk("f_awaddr_stable", bus.awaddr, 32'h8000_0104);
    chk("f_wdata_stable", bus.wdata, 32'h1111_1111);
    chk("f_head_pc", bus.head_pc, 32'h0000_0201);
    // Pop while full with in_valid still high: no push
    bus.wready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.wready = 1'b0;
    chk("pp_full_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("pp_full_gap", {31'd0, bus.awvalid}, 32'd0);
    chk("pp_full_head_pc", bus.head_pc, 32'h0000_0202);
    step();
    chk("pp3_awaddr", bus.awaddr, 32'h8000_0108);
    // Push and pop together from three entries
    set_store(32'h8000_0120, 32'hE5E5_E5E5, 5'd2, 32'h0000_02E5);
    bus.wready = 1'b1;
    step();
    bus.wready = 1'b0;
    chk("pp3_gap", {31'd0, bus.awvalid}, 32'd0);
    chk("pp3_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("pp3_head_pc", bus.head_pc, 32'h0000_0203);
    // One more push must make it full again (count was 3)
    set_store(32'h8000_0124, 32'hF6F6_F6F6, 5'd2, 32'h0000_02F6);
    step();
    bus.in_valid = 1'b0;
    chk("pp3_refill_full", {31'd0, bus.in_ready}, 32'd0);
    // Drain in FIFO order across the pointer wrap
    bus.wready = 1'b1;
    drain_one("d0", 32'h8000_010C, 32'h3333_3333);
    step();
    drain_one("d1", 32'h8000_0110, 32'h4444_4444);
    step();
    drain_one("d2", 32'h8000_0120, 32'hE5E5_E5E5);
    step();
    drain_one("d3", 32'h8000_0124, 32'hF6F6_F6F6);
    chk("d_sq_empty", {31'd0, bus.sq_empty}, 32'd1);
    step();
    step();
    chk("d_no_rejected_write", {31'd0, bus.awvalid}, 32'd0);
    chk("d_sq_empty_hold", {31'd0, bus.sq_empty}, 32'd1);

    // Load conflict
    bus.wready = 1'b0;
    set_store(32'h8000_0010, 32'h0000_0001, 5'd2, 32'h0000_0300);
    step();
    bus.in_valid = 1'b0;
    bus.lq_raddr = 32'h8000_0013;
    #1;
    chk("lq_hit", {31'd0, bus.lq_conflict}, 32'd1);
    bus.lq_raddr = 32'h8000_0014;
    #1;
    chk("lq_miss", {31'd0, bus.lq_conflict}, 32'd0);
    step();
    bus.lq_raddr = 32'h8000_0013;
    #1;
    chk("lq_hit_in_send", {31'd0, bus.lq_conflict}, 32'd1);
    bus.wready = 1'b1;
    step();
    #1;
    chk("lq_after_drain", {31'd0, bus.lq_conflict}, 32'd0);

    // Async reset while presenting a write
    bus.wready = 1'b0;
    set_store(32'h8000_0040, 32'hCAFE_F00D, 5'd2, 32'h0000_0400);
    step();
    bus.in_valid = 1'b0;
    step();
    chk("ar_awvalid_before", {31'd0, bus.awvalid}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("ar_awvalid_async", {31'd0, bus.awvalid}, 32'd0);
    chk("ar_sq_empty", {31'd0, bus.sq_empty}, 32'd1);
    chk("ar_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    reset = 1'b1;
    bus.wready = 1'b1;
    step();
    step();
    step();
    chk("ar_no_stale_write", {31'd0, bus.awvalid}, 32'd0);
    chk("ar_sq_empty_after", {31'd0, bus.sq_empty}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
